// File: rtl/ser_rx_decoder.sv
// ser_rx_decoder: 8N1 serial receiver with a small receive buffer.
// Define SER_RX_FIFO_EN for a 4-entry FIFO; otherwise a 1-byte holding register.
module ser_rx_decoder #(
   parameter int unsigned CLKS_PER_BIT = 106
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t      state;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;
   logic [15:0] cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        tick;
   logic        push;
   logic        pop;
   logic        full;
   logic        wr_en;
   logic        drop;

   assign tick  = (cnt == 16'd0);
   assign push  = (state == STOP) && tick && rx_s2;
   assign pop   = rx_valid && rx_ready;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;
   assign busy  = (state != IDLE);

   // Two-flop synchronizer plus one history flop for falling-edge detect
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Frame state machine: mid-bit sampling, LSB-first shift, stop check
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rx_s2 && rx_prev) begin
                  state <= START;
                  cnt   <= HALF;
               end
            end
            START: begin
               if (tick) begin
                  if (rx_s2) begin
                     state <= IDLE;
                  end else begin
                     state   <= DATA;
                     cnt     <= FULL;
                     bit_idx <= 3'd0;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            DATA: begin
               if (tick) begin
                  shreg   <= {rx_s2, shreg[7:1]};
                  cnt     <= FULL;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            STOP: begin
               if (tick) begin
                  frame_err <= !rx_s2;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Overrun pulses when a good byte arrives with no room and no pop
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else begin
         overrun <= drop;
      end
   end

`ifdef SER_RX_FIFO_EN
   logic [7:0] mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;

   assign full     = (count == 3'd4);
   assign rx_valid = (count != 3'd0);
   assign rx_data  = mem[rd_ptr];

   // Four-entry circular FIFO; pointers wrap naturally at 2 bits
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < 4; i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= shreg;
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         count <= count + {2'b00, wr_en} - {2'b00, pop};
      end
   end
`else
   logic [7:0] hold;
   logic       hold_v;

   assign full     = hold_v;
   assign rx_valid = hold_v;
   assign rx_data  = hold;

   // Single holding register; a write in the pop cycle keeps it valid
   always_ff @(posedge clk) begin
      if (reset) begin
         hold   <= 8'h00;
         hold_v <= 1'b0;
      end else begin
         if (wr_en) begin
            hold   <= shreg;
            hold_v <= 1'b1;
         end else if (pop) begin
            hold_v <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ser_rx_decoder.sv
// tb_ser_rx_decoder: directed frames against a queue-based receiver model.
// Define SER_RX_FIFO_EN to run the 4-deep FIFO scenario.
module tb_ser_rx_decoder;

   localparam int CPB    = 106;
   localparam int HALF   = CPB / 2 - 1;
   localparam int EV_LAT = 4 + HALF + 9 * CPB;
`ifdef SER_RX_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] q [$];
   int         ev_cyc  = -1;
   logic [7:0] ev_byte = 8'h00;
   logic       ev_stop = 1'b1;
   int         b_from  = 0;
   int         b_to    = 0;
   logic       exp_fe  = 1'b0;
   logic       exp_ov  = 1'b0;
   logic       m_pop;

   always #5 clk = ~clk;

   ser_rx_decoder #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Reference model: byte queue plus scheduled stop-sample events
   always @(posedge clk) begin
      cyc++;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (reset) begin
         q.delete();
         ev_cyc = -1;
         b_to   = 0;
      end else begin
         m_pop = (q.size() > 0) && rx_ready;
         if (m_pop) void'(q.pop_front());
         if (cyc == ev_cyc) begin
            if (!ev_stop) exp_fe = 1'b1;
            else if (q.size() < DEPTH) q.push_back(ev_byte);
            else exp_ov = 1'b1;
         end
      end
   end

   // Compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("rx_valid", rx_valid, q.size() > 0);
         if (q.size() > 0) chk("rx_data", rx_data, q[0]);
         chk("frame_err", frame_err, exp_fe);
         chk("overrun", overrun, exp_ov);
         chk("busy", busy, (cyc >= b_from) && (cyc < b_to));
         chk("err_excl", frame_err && overrun, 1'b0);
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop,
                             input int abort_at);
      logic [9:0] bits;
      int k;
      bits    = {stop, b, 1'b0};
      k       = cyc;
      ev_cyc  = k + EV_LAT;
      ev_byte = b;
      ev_stop = stop;
      b_from  = k + 3;
      b_to    = k + EV_LAT;
      for (int i = 0; i < 10; i++) begin
         rx = bits[i];
         for (int j = 0; j < CPB; j++) begin
            if (abort_at > 0 && i * CPB + j == abort_at) begin
               reset = 1'b1;
               rx    = 1'b1;
               repeat (2) begin
                  @(posedge clk);
                  #1;
               end
               reset = 1'b0;
               return;
            end
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      int k;
      rx       = 1'b1;
      reset    = 1'b1;
      rx_ready = 1'b1;
      idle(3);
      @(negedge clk);
      chk("rst_valid", rx_valid, 1'b0);
      chk("rst_data", rx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_fe", frame_err, 1'b0);
      chk("rst_ov", overrun, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(5);

      // good frame 0x55
      k = cyc;
      fork
         send_frame(8'h55, 1'b1, 0);
         begin
            while (cyc < k + EV_LAT) @(negedge clk);
            chk("f55_valid", rx_valid, 1'b1);
            chk("f55_data", rx_data, 8'h55);
            chk("f55_fe", frame_err, 1'b0);
            @(negedge clk);
            chk("f55_popped", rx_valid, 1'b0);
         end
      join
      idle(10);

      // false start: 20 low cycles
      k      = cyc;
      b_from = k + 3;
      b_to   = k + 4 + HALF;
      rx     = 1'b0;
      idle(20);
      rx = 1'b1;
      while (cyc < k + 4 + HALF) @(negedge clk);
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_valid", rx_valid, 1'b0);
      @(posedge clk);
      #1;
      idle(100);

      // bad stop bit 0xA3
      k = cyc;
      fork
         send_frame(8'hA3, 1'b0, 0);
         begin
            while (cyc < k + EV_LAT) @(negedge clk);
            chk("fa3_fe", frame_err, 1'b1);
            chk("fa3_valid", rx_valid, 1'b0);
            @(negedge clk);
            chk("fa3_fe_end", frame_err, 1'b0);
         end
      join
      rx = 1'b1;
      idle(10);

      // buffer full scenarios
      rx_ready = 1'b0;
`ifdef SER_RX_FIFO_EN
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0);
      k = cyc;
      fork
         send_frame(8'h05, 1'b1, 0);
         begin
            while (cyc < k + EV_LAT) @(negedge clk);
            chk("ff_ov", overrun, 1'b1);
            chk("ff_head", rx_data, 8'h01);
         end
      join
      rx_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk("ff_order", rx_data, 8'(i));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("ff_empty", rx_valid, 1'b0);
      @(posedge clk);
      #1;
`else
      send_frame(8'h10, 1'b1, 0);
      k = cyc;
      fork
         send_frame(8'h20, 1'b1, 0);
         begin
            while (cyc < k + EV_LAT) @(negedge clk);
            chk("h_ov", overrun, 1'b1);
            chk("h_keep", rx_data, 8'h10);
            @(negedge clk);
            chk("h_ov_end", overrun, 1'b0);
         end
      join
      @(negedge clk);
      chk("h_data", rx_data, 8'h10);
      chk("h_valid", rx_valid, 1'b1);
      @(posedge clk);
      #1;
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("h_popped", rx_valid, 1'b0);
      @(posedge clk);
      #1;
`endif
      idle(20);

      // reset during data bit 4 of 0xC3, then 0x3C
      send_frame(8'hC3, 1'b1, 5 * CPB + 30);
      @(negedge clk);
      chk("rr_busy", busy, 1'b0);
      chk("rr_valid", rx_valid, 1'b0);
      @(posedge clk);
      #1;
      idle(20);
      k = cyc;
      fork
         send_frame(8'h3C, 1'b1, 0);
         begin
            while (cyc < k + EV_LAT) @(negedge clk);
            chk("f3c_valid", rx_valid, 1'b1);
            chk("f3c_data", rx_data, 8'h3C);
         end
      join
      idle(10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
